// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: decodes car direction from two synchronized
// photo-sensor beams and keeps a saturating occupancy count with sticky error flags.
module parking_lot_ctrl #(
  parameter int CAPACITY = 25,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  output logic          enter,
  output logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic          enter_q, enter_d;
  logic          exit_q, exit_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [1:0]    ab_s;
  logic          entry_done_s;
  logic          exit_done_s;

  assign ab_s = {a, b};

  // Next-state decode: hold on own pattern, step back on previous, advance on next, else abort.
  always_comb begin
    state_d      = state_q;
    entry_done_s = 1'b0;
    exit_done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab_s)
          2'b10:   state_d = E1;
          2'b01:   state_d = X1;
          default: state_d = IDLE;
        endcase
      end
      E1: begin
        case (ab_s)
          2'b10:   state_d = E1;
          2'b11:   state_d = E2;
          default: state_d = IDLE;
        endcase
      end
      E2: begin
        case (ab_s)
          2'b11:   state_d = E2;
          2'b10:   state_d = E1;
          2'b01:   state_d = E3;
          default: state_d = IDLE;
        endcase
      end
      E3: begin
        case (ab_s)
          2'b01:   state_d = E3;
          2'b11:   state_d = E2;
          2'b00: begin
            state_d      = IDLE;
            entry_done_s = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      X1: begin
        case (ab_s)
          2'b01:   state_d = X1;
          2'b11:   state_d = X2;
          default: state_d = IDLE;
        endcase
      end
      X2: begin
        case (ab_s)
          2'b11:   state_d = X2;
          2'b01:   state_d = X1;
          2'b10:   state_d = X3;
          default: state_d = IDLE;
        endcase
      end
      X3: begin
        case (ab_s)
          2'b10:   state_d = X3;
          2'b11:   state_d = X2;
          2'b00: begin
            state_d     = IDLE;
            exit_done_s = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and flag update on a completed crossing; pulses are issued even when saturated.
  always_comb begin
    enter_d = entry_done_s;
    exit_d  = exit_done_s;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (entry_done_s) begin
      if (count_q < CAP_C) begin
        count_d = count_q + ONE_C;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (exit_done_s) begin
      if (count_q > ZERO_C) begin
        count_d = count_q - ONE_C;
      end else begin
        unf_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers; reset discards any crossing in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      count_q <= ZERO_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign enter = enter_q;
  assign exit  = exit_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign full  = (count_q == CAP_C);
  assign empty = (count_q == ZERO_C);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: directed scenarios with literal expectations, then
// randomized crossings checked every cycle against a path-position occupancy model.
module tb_parking_lot_ctrl;

  localparam int CAP = 3;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          a, b;
  logic          enter, exit;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;
  int enter_seen = 0;
  int exit_seen  = 0;

  // model state: direction (+1 entry, -1 exit, 0 none) and steps taken along the path
  int dir = 0;
  int pos = 0;
  int cnt = 0;
  bit m_enter = 1'b0, m_exit = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  bit started = 1'b0;

  logic [1:0] ent_path [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ext_path [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  parking_lot_ctrl #(.CAPACITY(CAP), .CW(CW)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .enter(enter), .exit(exit), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] path_at(input int d, input int i);
    if (i < 0) return 2'b00;
    return (d > 0) ? ent_path[i] : ext_path[i];
  endfunction

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // reference model, advanced on every sampling edge
  always @(posedge clk) begin
    logic [1:0] ab;
    ab = {a, b};
    m_enter = 1'b0;
    m_exit  = 1'b0;
    if (reset) begin
      dir = 0; pos = 0; cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
      started = 1'b1;
    end else if (dir == 0) begin
      if (ab == 2'b10) begin dir = 1; pos = 1; end
      else if (ab == 2'b01) begin dir = -1; pos = 1; end
    end else if (ab == path_at(dir, pos - 1)) begin
      pos = pos;
    end else if (ab == path_at(dir, pos - 2)) begin
      pos = pos - 1;
      if (pos == 0) dir = 0;
    end else if (ab == path_at(dir, pos)) begin
      pos = pos + 1;
      if (pos == 4) begin
        if (dir > 0) begin
          m_enter = 1'b1;
          if (cnt < CAP) cnt = cnt + 1; else m_ovf = 1'b1;
        end else begin
          m_exit = 1'b1;
          if (cnt > 0) cnt = cnt - 1; else m_unf = 1'b1;
        end
        dir = 0; pos = 0;
      end
    end else begin
      dir = 0; pos = 0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      cmp("enter", int'(enter), int'(m_enter));
      cmp("exit",  int'(exit),  int'(m_exit));
      cmp("count", int'(count), cnt);
      cmp("full",  int'(full),  int'(cnt == CAP));
      cmp("empty", int'(empty), int'(cnt == 0));
      cmp("ovf",   int'(ovf),   int'(m_ovf));
      cmp("unf",   int'(unf),   int'(m_unf));
      cmp("pulse_excl", int'(enter & exit), 0);
      if (enter) enter_seen++;
      if (exit) exit_seen++;
    end
  end

  task automatic hold(input logic [1:0] p, input int n);
    {a, b} = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic crossing(input bit is_entry, input int n);
    for (int i = 0; i < 4; i++) hold(is_entry ? ent_path[i] : ext_path[i], n);
  endtask

  task automatic rand_crossing();
    bit         ent;
    logic [1:0] p;
    ent = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) begin
      p = ent ? ent_path[i] : ext_path[i];
      if ($urandom_range(0, 9) == 0) p = 2'($urandom_range(0, 3));
      hold(p, $urandom_range(1, 3));
      if (i > 0 && i < 3 && $urandom_range(0, 7) == 0) begin
        hold(ent ? ent_path[i-1] : ext_path[i-1], $urandom_range(1, 2));
        hold(p, $urandom_range(1, 2));
      end
    end
    if ($urandom_range(0, 39) == 0) do_reset(1);
  endtask

  initial begin
    int e0, x0;
    a = 1'b0; b = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset then idle
    hold(2'b00, 10);
    cmp("idle_count", int'(count), 0);
    cmp("idle_empty", int'(empty), 1);
    cmp("idle_full", int'(full), 0);
    cmp("idle_flags", int'({ovf, unf}), 0);
    cmp("idle_pulses", enter_seen + exit_seen, 0);

    // single entry with pulse timing on the 00 sample edge
    e0 = enter_seen;
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    cmp("entry_not_early", int'(count), 0);
    hold(2'b00, 1);
    cmp("entry_pulse", int'(enter), 1);
    cmp("entry_count", int'(count), 1);
    hold(2'b00, 1);
    cmp("entry_pulse_drop", int'(enter), 0);
    hold(2'b00, 1);
    cmp("entry_pulses", enter_seen - e0, 1);

    // single exit
    x0 = exit_seen;
    crossing(1'b0, 3);
    cmp("exit_count", int'(count), 0);
    cmp("exit_empty", int'(empty), 1);
    cmp("exit_pulses", exit_seen - x0, 1);

    // back-out and glitch
    e0 = enter_seen; x0 = exit_seen;
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 2);
    hold(2'b10, 2); hold(2'b01, 2); hold(2'b00, 2); hold(2'b01, 2); hold(2'b00, 2);
    cmp("backout_pulses", (enter_seen - e0) + (exit_seen - x0), 0);
    cmp("backout_count", int'(count), 0);

    // saturation at CAP=3
    do_reset(2);
    e0 = enter_seen; x0 = exit_seen;
    for (int k = 0; k < 3; k++) crossing(1'b1, 2);
    cmp("sat_full", int'(full), 1);
    cmp("sat_no_ovf_yet", int'(ovf), 0);
    crossing(1'b1, 2);
    cmp("sat_count", int'(count), 3);
    cmp("sat_ovf", int'(ovf), 1);
    cmp("sat_enters", enter_seen - e0, 4);
    for (int k = 0; k < 4; k++) crossing(1'b0, 2);
    cmp("unf_count", int'(count), 0);
    cmp("unf_flag", int'(unf), 1);
    cmp("unf_ovf_sticky", int'(ovf), 1);
    cmp("unf_exits", exit_seen - x0, 4);

    // reset mid-crossing on the completing edge
    do_reset(1);
    crossing(1'b1, 2);
    cmp("pre_reset_count", int'(count), 1);
    e0 = enter_seen;
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b01, 2);
    reset = 1'b1;
    hold(2'b00, 1);
    reset = 1'b0;
    cmp("mid_reset_enter", enter_seen - e0, 0);
    cmp("mid_reset_count", int'(count), 0);
    x0 = exit_seen;
    hold(2'b01, 1); hold(2'b11, 1); hold(2'b10, 1); hold(2'b00, 2);
    cmp("mid_reset_x1_exit", exit_seen - x0, 1);
    cmp("mid_reset_unf", int'(unf), 1);

    // back-to-back entries
    do_reset(1);
    e0 = enter_seen;
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 1);
    hold(2'b10, 1); hold(2'b11, 1); hold(2'b01, 1); hold(2'b00, 2);
    cmp("b2b_count", int'(count), 2);
    cmp("b2b_enters", enter_seen - e0, 2);

    // holding produces no events
    e0 = enter_seen; x0 = exit_seen;
    hold(2'b11, 20); hold(2'b00, 20);
    cmp("hold_no_events", (enter_seen - e0) + (exit_seen - x0), 0);

    // randomized crossings
    do_reset(1);
    for (int k = 0; k < 500; k++) rand_crossing();
    hold(2'b00, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
